product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N, default 32, operand width of the upstream multiplier; product width is 2*N.
REQ-002 Parameter COUNT, default 8, number of products summed per block (legal range 1..255).
REQ-003 Parameter GUARD, default 8, extra accumulator MSBs; ACC_W = 2*N+GUARD.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset is asynchronous and active-low.
REQ-006 start  input  1  begin a new accumulation block.
REQ-007 prod_valid  input  1  one-cycle strobe: product is valid this cycle.
REQ-008 product  input  2*N  unsigned product from the upstream multiplier.
REQ-009 sum  output  ACC_W  registered block sum.
REQ-010 sum_valid  output  1  sum holds a completed block.
REQ-011 sum_ready  input  1  consumer accepts sum.
REQ-012 busy  output  1  block in progress (state ACCUM).
REQ-013 count  output  8  products accepted in the current block.
REQ-014 overflow  output  1  sticky: carry out of ACC_W occurred in the current block.
REQ-015 drop  output  1  sticky: prod_valid arrived while not accepting.

Function
REQ-016 FSM states: IDLE, ACCUM, DONE; busy=1 only in ACCUM, sum_valid=1 only in DONE.
REQ-017 IDLE: start -> clear accumulator, count, overflow, drop; next state ACCUM; prod_valid without start -> set drop, no accumulation.
REQ-018 ACCUM: prod_valid -> accumulator += zero-extended product, count += 1, same edge.
REQ-019 ACCUM: accepting the COUNT-th product -> next state DONE; sum = final accumulator; sum_valid high the cycle after that strobe (latency 1).
REQ-020 ACCUM: start -> restart (clear as REQ-017, remain ACCUM); a prod_valid in the same cycle is discarded and does not set drop.
REQ-021 Addition is modulo 2^ACC_W; a carry out sets overflow, which stays set until the next start or reset.
REQ-022 DONE: sum, count, overflow held stable while sum_ready=0.
REQ-023 DONE: prod_valid -> discarded, drop set; sum unchanged.
REQ-024 DONE: sum_valid and sum_ready -> handshake completes; next state IDLE, or ACCUM with clear if start is high in the same cycle.
REQ-025 DONE: start without sum_ready is ignored; the block is never lost unacknowledged.
REQ-026 sum updates only on entry to DONE; outside DONE it holds the last completed sum.

Reset
REQ-027 reset low -> immediately, independent of clk: state IDLE; sum, accumulator, count, sum_valid, busy, overflow, drop all 0.
REQ-028 Reset mid-block discards partial accumulation; no sum_valid is produced for that block.
REQ-029 After reset release, first state change requires a start sampled on a rising edge.

Verification
REQ-030 N=32, COUNT=4, GUARD=8: start, products 1,2,3,4 on consecutive cycles, sum_ready=1 -> sum=10, sum_valid high exactly one cycle after the 4th strobe, then IDLE.
REQ-031 COUNT=4, GUARD=1: four products 0xFFFF_FFFF_FFFF_FFFF -> sum=0x1_FFFF_FFFF_FFFF_FFFC, overflow=1; the same stimulus with GUARD=8 -> sum=0x3_FFFF_FFFF_FFFF_FFFC, overflow=0.
REQ-032 Block complete, sum_ready low 5 cycles with 2 prod_valid pulses -> sum stable, drop=1, sum_valid high until sum_ready rises.
REQ-033 Reset asserted after 2 of 4 products, between edges -> outputs 0 at once; prod_valid after release without start -> count stays 0, drop=1.
REQ-034 ACCUM with count=2: start and prod_valid in the same cycle -> count=0, accumulator 0, drop=0.
REQ-035 DONE, sum_ready and start in the same cycle -> next cycle busy=1, sum_valid=0, count=0.

Source files
------------

// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Groups the block-control, product-input and sum-output signals of the
//   product accumulator.
//   master : drives start, prod_valid, product, sum_ready; observes the rest
//   slave  : the accumulator; drives sum, sum_valid, busy, count, overflow, drop
//   N      : upstream multiplier operand width (product is 2*N bits)
//   GUARD  : extra accumulator MSBs (sum is 2*N+GUARD bits)
interface product_accumulator_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned GUARD = 8
);
  localparam int unsigned ACC_W = 2 * N + GUARD;

  logic               start;
  logic               prod_valid;
  logic [2*N-1:0]     product;
  logic               sum_ready;
  logic [ACC_W-1:0]   sum;
  logic               sum_valid;
  logic               busy;
  logic [7:0]         count;
  logic               overflow;
  logic               drop;

  modport master (
    output start, prod_valid, product, sum_ready,
    input  sum, sum_valid, busy, count, overflow, drop
  );

  modport slave (
    input  start, prod_valid, product, sum_ready,
    output sum, sum_valid, busy, count, overflow, drop
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums blocks of COUNT unsigned 2*N-bit products into a 2*N+GUARD-bit
//   accumulator and hands the block sum to a consumer with a valid/ready
//   handshake.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : product_accumulator_if.slave
//     start      - begin (or restart) a block
//     prod_valid - one-cycle strobe, product valid
//     product    - unsigned product (2*N bits)
//     sum_ready  - consumer accepts sum
//     sum        - registered sum of the last completed block
//     sum_valid  - sum holds a completed, unacknowledged block
//     busy       - block in progress
//     count      - products accepted in the current block
//     overflow   - sticky carry out of the accumulator in this block
//     drop       - sticky: a product arrived while not accepting
module product_accumulator #(
  parameter int unsigned N     = 32,
  parameter int unsigned COUNT = 8,
  parameter int unsigned GUARD = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  product_accumulator_if.slave   bus
);

  localparam int unsigned ACC_W    = 2 * N + GUARD;
  localparam logic [7:0]  LAST_CNT = 8'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;

  // One extra bit captures the carry out of the accumulator.
  logic [ACC_W:0]   add_w;
  logic             clr_w;

  always_comb begin
    add_w = {1'b0, acc_q} + {{(GUARD + 1){1'b0}}, bus.product};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    clr_w   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr_w   = 1'b1;
          state_d = ACCUM;
        end else if (bus.prod_valid) begin
          drop_d = 1'b1;
        end
      end

      ACCUM: begin
        // A restart discards any product strobed in the same cycle.
        if (bus.start) begin
          clr_w = 1'b1;
        end else if (bus.prod_valid) begin
          acc_d   = add_w[ACC_W-1:0];
          count_d = count_q + 8'd1;
          if (add_w[ACC_W]) begin
            ovf_d = 1'b1;
          end
          if (count_q == LAST_CNT) begin
            sum_d   = add_w[ACC_W-1:0];
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (bus.prod_valid) begin
          drop_d = 1'b1;
        end
        // start only takes effect together with the handshake, so an
        // unacknowledged block is never overwritten.
        if (bus.sum_ready) begin
          if (bus.start) begin
            clr_w   = 1'b1;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr_w) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.sum_valid = (state_q == DONE);
  assign bus.busy      = (state_q == ACCUM);
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Two accumulators (GUARD=8 and GUARD=1) share one stimulus stream and are
//   compared every cycle against a reference that keeps the accepted
//   products of the current block in a queue and derives sum/overflow from
//   their exact arithmetic total.
module tb_product_accumulator;

  localparam int unsigned N     = 32;
  localparam int unsigned COUNT = 4;
  localparam int unsigned GA    = 8;
  localparam int unsigned GB    = 1;
  localparam int unsigned AW_A  = 2 * N + GA;
  localparam int unsigned AW_B  = 2 * N + GB;
  localparam logic [127:0] MASK_A = (128'd1 << AW_A) - 128'd1;
  localparam logic [127:0] MASK_B = (128'd1 << AW_B) - 128'd1;
  localparam logic [63:0]  ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  product_accumulator_if #(.N(N), .GUARD(GA)) ia ();
  product_accumulator_if #(.N(N), .GUARD(GB)) ib ();

  product_accumulator #(.N(N), .COUNT(COUNT), .GUARD(GA)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ia)
  );

  product_accumulator #(.N(N), .COUNT(COUNT), .GUARD(GB)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ib)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Current drive values
  logic        d_start, d_pv, d_ready;
  logic [63:0] d_prod;

  task automatic drive(input logic s, input logic pv, input logic [63:0] p, input logic r);
    d_start = s; d_pv = pv; d_prod = p; d_ready = r;
    ia.start = s; ia.prod_valid = pv; ia.product = p; ia.sum_ready = r;
    ib.start = s; ib.prod_valid = pv; ib.product = p; ib.sum_ready = r;
  endtask

  // Reference: phase 0 = waiting for start, 1 = collecting, 2 = holding result
  int           ph;
  logic [127:0] prods[$];
  logic [127:0] last_total;
  bit           m_drop;

  function automatic logic [127:0] running_total();
    logic [127:0] t = '0;
    foreach (prods[i]) t += prods[i];
    return t;
  endfunction

  task automatic model_clear();
    prods.delete();
    m_drop = 1'b0;
  endtask

  task automatic model_reset();
    ph = 0;
    prods.delete();
    last_total = '0;
    m_drop = 1'b0;
  endtask

  task automatic model_edge();
    case (ph)
      0: begin
        if (d_start) begin model_clear(); ph = 1; end
        else if (d_pv) m_drop = 1'b1;
      end
      1: begin
        if (d_start) model_clear();
        else if (d_pv) begin
          prods.push_back({64'd0, d_prod});
          if (prods.size() == COUNT) begin
            last_total = running_total();
            ph = 2;
          end
        end
      end
      default: begin
        if (d_pv) m_drop = 1'b1;
        if (d_ready) begin
          if (d_start) begin model_clear(); ph = 1; end
          else ph = 0;
        end
      end
    endcase
  endtask

  task automatic compare();
    logic [127:0] rt;
    rt = running_total();
    check("a.sum",       ia.sum,       last_total & MASK_A);
    check("b.sum",       ib.sum,       last_total & MASK_B);
    check("a.sum_valid", ia.sum_valid, (ph == 2));
    check("b.sum_valid", ib.sum_valid, (ph == 2));
    check("a.busy",      ia.busy,      (ph == 1));
    check("b.busy",      ib.busy,      (ph == 1));
    check("a.count",     ia.count,     prods.size());
    check("b.count",     ib.count,     prods.size());
    check("a.overflow",  ia.overflow,  (rt >> AW_A) != 0);
    check("b.overflow",  ib.overflow,  (rt >> AW_B) != 0);
    check("a.drop",      ia.drop,      m_drop);
    check("b.drop",      ib.drop,      m_drop);
  endtask

  // Entered just after a negedge; leaves just after the following negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare();
    check("rst a.sum_valid", ia.sum_valid, 1'b0);
    check("rst a.count",     ia.count,     8'd0);
    @(negedge clk);
    compare();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 1'b0);
    model_reset();
    @(negedge clk);
    compare();
    reset = 1'b1;

    // Idle with nothing asserted stays idle
    step();
    check("idle busy", ia.busy, 1'b0);

    // Basic block 1+2+3+4, consumer always ready
    drive(1'b1, 1'b0, 64'd0, 1'b1); step();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 64'(i), 1'b1); step();
    end
    check("basic sum", ia.sum, 72'd10);
    check("basic sum_valid", ia.sum_valid, 1'b1);
    drive(1'b0, 1'b0, 64'd0, 1'b1); step();
    check("basic idle", ia.sum_valid, 1'b0);

    // All-ones products: GUARD=1 wraps, GUARD=8 does not
    drive(1'b1, 1'b0, 64'd0, 1'b0); step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, ONES64, 1'b0); step();
    end
    check("wide sum", ia.sum, 72'h3_FFFF_FFFF_FFFF_FFFC);
    check("wide ovf", ia.overflow, 1'b0);
    check("narrow sum", ib.sum, 65'h1_FFFF_FFFF_FFFF_FFFC);
    check("narrow ovf", ib.overflow, 1'b1);

    // Back-pressure with stray products while holding the result
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, (i == 1 || i == 3), 64'h55, 1'b0); step();
    end
    check("hold sum", ia.sum, 72'h3_FFFF_FFFF_FFFF_FFFC);
    check("hold drop", ia.drop, 1'b1);
    check("hold valid", ia.sum_valid, 1'b1);
    drive(1'b1, 1'b0, 64'd0, 1'b0); step();   // start without ready is ignored
    check("start ignored", ia.sum_valid, 1'b1);
    drive(1'b0, 1'b0, 64'd0, 1'b1); step();

    // Reset in the middle of a block, then a product without start
    drive(1'b1, 1'b0, 64'd0, 1'b1); step();
    drive(1'b0, 1'b1, 64'd7, 1'b1); step();
    drive(1'b0, 1'b1, 64'd9, 1'b1); step();
    drive(1'b0, 1'b0, 64'd0, 1'b1);
    async_reset();
    drive(1'b0, 1'b1, 64'd3, 1'b1); step();
    check("post-rst count", ia.count, 8'd0);
    check("post-rst drop", ia.drop, 1'b1);

    // Restart with a simultaneous product mid-block
    drive(1'b1, 1'b0, 64'd0, 1'b0); step();
    drive(1'b0, 1'b1, 64'd100, 1'b0); step();
    drive(1'b0, 1'b1, 64'd200, 1'b0); step();
    drive(1'b1, 1'b1, 64'd300, 1'b0); step();
    check("restart count", ia.count, 8'd0);
    check("restart drop", ia.drop, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 64'(5 + i), 1'b0); step();
    end
    check("restart sum", ia.sum, 72'd26);

    // Handshake and start in the same cycle
    drive(1'b1, 1'b0, 64'd0, 1'b1); step();
    check("hs+start busy", ia.busy, 1'b1);
    check("hs+start valid", ia.sum_valid, 1'b0);
    check("hs+start count", ia.count, 8'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] p;
      p = ($urandom_range(0, 3) == 0) ? ONES64 : {$urandom, $urandom};
      drive($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1, p, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) async_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
